// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and encodings for the imem/dmem memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MEM  = 2'd1,
    RD_RSP  = 2'd2,
    WR_DATA = 2'd3
  } state_t;

  localparam logic CMD_RD    = 1'b0;
  localparam logic CMD_WR    = 1'b1;

  localparam logic PORT_IMEM = 1'b0;
  localparam logic PORT_DMEM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side imem (read-only) and dmem (read/write) valid/ready channels.
interface mem_port_arbiter_if #(
  parameter int p_ADDR_BITS = 32,
  parameter int p_DATA_BITS = 32,
  parameter int p_STRB_BITS = p_DATA_BITS / 8
);
  logic [p_ADDR_BITS-1:0] imem_addr;
  logic                   imem_valid;
  logic                   imem_ready;
  logic                   imem_r_valid;
  logic                   imem_r_ready;
  logic [p_DATA_BITS-1:0] imem_r_data;

  logic [p_ADDR_BITS-1:0] dmem_addr;
  logic                   dmem_cmd;
  logic                   dmem_valid;
  logic                   dmem_ready;
  logic                   dmem_r_valid;
  logic                   dmem_r_ready;
  logic [p_DATA_BITS-1:0] dmem_r_data;
  logic                   dmem_w_valid;
  logic                   dmem_w_ready;
  logic [p_STRB_BITS-1:0] dmem_w_strb;
  logic [p_DATA_BITS-1:0] dmem_w_data;

  modport master (
    output imem_addr, imem_valid, imem_r_ready,
    input  imem_ready, imem_r_valid, imem_r_data,
    output dmem_addr, dmem_cmd, dmem_valid, dmem_r_ready,
    output dmem_w_valid, dmem_w_strb, dmem_w_data,
    input  dmem_ready, dmem_r_valid, dmem_r_data, dmem_w_ready
  );

  modport slave (
    input  imem_addr, imem_valid, imem_r_ready,
    output imem_ready, imem_r_valid, imem_r_data,
    input  dmem_addr, dmem_cmd, dmem_valid, dmem_r_ready,
    input  dmem_w_valid, dmem_w_strb, dmem_w_data,
    output dmem_ready, dmem_r_valid, dmem_r_data, dmem_w_ready
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted port.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last;

  // On a tie, the port that did not win last time is granted.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = (last == PORT_DMEM) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      last <= PORT_DMEM;
    else if (|gnt) last <= gnt[1];
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between imem reads and dmem reads/writes.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int p_ADDR_BITS = 32,
  parameter int p_DATA_BITS = 32,
  parameter int p_STRB_BITS = p_DATA_BITS / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_port_arbiter_if.slave      bus,
  output logic [p_ADDR_BITS-1:0] mem_addr,
  output logic                   mem_rden,
  input  logic [p_DATA_BITS-1:0] mem_rddata,
  output logic                   mem_wren,
  output logic [p_STRB_BITS-1:0] mem_wrstrb,
  output logic [p_DATA_BITS-1:0] mem_wrdata
);
  state_t                 state, state_nxt;
  logic [p_ADDR_BITS-1:0] lat_waddr;
  logic                   lat_port, lat_cmd;
  logic [p_DATA_BITS-1:0] hold;

  logic [1:0]             req, gnt;
  logic                   arb_en;
  logic                   acc_port, acc_cmd;
  logic [p_ADDR_BITS-1:0] acc_addr, acc_waddr;
  logic                   unused_addr_lsbs;

  logic                   imem_r_valid, dmem_r_valid, dmem_w_ready;
  logic [p_DATA_BITS-1:0] imem_r_data, dmem_r_data;

  // Gating with rst keeps ready low while reset is asserted even if requests are up.
  assign arb_en = rst && (state == IDLE);
  assign req    = {bus.dmem_valid, bus.imem_valid};

  rr_arb2 u_rr (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign acc_port         = gnt[1];
  assign acc_cmd          = gnt[1] ? bus.dmem_cmd : CMD_RD;
  assign acc_addr         = gnt[1] ? bus.dmem_addr : bus.imem_addr;
  assign acc_waddr        = {2'b00, acc_addr[p_ADDR_BITS-1:2]};
  assign unused_addr_lsbs = ^acc_addr[1:0];

  always_comb begin
    state_nxt    = state;
    mem_addr     = '0;
    mem_rden     = 1'b0;
    mem_wren     = 1'b0;
    mem_wrstrb   = '0;
    mem_wrdata   = '0;
    imem_r_valid = 1'b0;
    imem_r_data  = '0;
    dmem_r_valid = 1'b0;
    dmem_r_data  = '0;
    dmem_w_ready = 1'b0;
    case (state)
      IDLE: begin
        if (|gnt) begin
          if (acc_cmd == CMD_RD) begin
            mem_rden  = 1'b1;
            mem_addr  = acc_waddr;
            state_nxt = RD_MEM;
          end else begin
            state_nxt = WR_DATA;
          end
        end
      end
      RD_MEM: state_nxt = RD_RSP;
      RD_RSP: begin
        if (lat_port == PORT_IMEM) begin
          imem_r_valid = 1'b1;
          imem_r_data  = hold;
          if (bus.imem_r_ready) state_nxt = IDLE;
        end else begin
          dmem_r_valid = 1'b1;
          dmem_r_data  = hold;
          if (bus.dmem_r_ready) state_nxt = IDLE;
        end
      end
      WR_DATA: begin
        dmem_w_ready = (lat_cmd == CMD_WR);
        if (dmem_w_ready && bus.dmem_w_valid) begin
          mem_wren   = 1'b1;
          mem_addr   = lat_waddr;
          mem_wrstrb = bus.dmem_w_strb;
          mem_wrdata = bus.dmem_w_data;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_waddr <= '0;
      lat_port  <= PORT_IMEM;
      lat_cmd   <= CMD_RD;
      hold      <= '0;
    end else begin
      state <= state_nxt;
      if (|gnt) begin
        lat_waddr <= acc_waddr;
        lat_port  <= acc_port;
        lat_cmd   <= acc_cmd;
      end
      if (state == RD_MEM) hold <= mem_rddata;
    end
  end

  assign bus.imem_ready   = gnt[0];
  assign bus.dmem_ready   = gnt[1];
  assign bus.imem_r_valid = imem_r_valid;
  assign bus.imem_r_data  = imem_r_data;
  assign bus.dmem_r_valid = dmem_r_valid;
  assign bus.dmem_r_data  = dmem_r_data;
  assign bus.dmem_w_ready = dmem_w_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-strobed behavioural memory.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.p_ADDR_BITS(32), .p_DATA_BITS(32), .p_STRB_BITS(4)) bus ();

  logic [31:0] mem_addr, mem_rddata, mem_wrdata;
  logic        mem_rden, mem_wren;
  logic [3:0]  mem_wrstrb;
  logic [31:0] ram [0:255];

  int n_assert = 0;
  int n_fail   = 0;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .mem_addr   (mem_addr),
    .mem_rden   (mem_rden),
    .mem_rddata (mem_rddata),
    .mem_wren   (mem_wren),
    .mem_wrstrb (mem_wrstrb),
    .mem_wrdata (mem_wrdata)
  );

  initial begin
    for (int k = 0; k < 256; k++) ram[k] = 32'h0;
    ram[8'h40] = 32'hDEADBEEF;
    ram[8'h80] = 32'hCAFEF00D;
    ram[8'h00] = 32'h0BADF00D;
    mem_rddata = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_rden) mem_rddata <= ram[mem_addr[7:0]];
    if (mem_wren)
      for (int b = 0; b < 4; b++)
        if (mem_wrstrb[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wrdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] rdy();
    return {30'd0, bus.dmem_ready, bus.imem_ready};
  endfunction

  function automatic logic [31:0] rvld();
    return {30'd0, bus.dmem_r_valid, bus.imem_r_valid};
  endfunction

  initial begin
    bus.imem_addr = '0; bus.imem_valid = 0; bus.imem_r_ready = 0;
    bus.dmem_addr = '0; bus.dmem_cmd = CMD_RD; bus.dmem_valid = 0; bus.dmem_r_ready = 0;
    bus.dmem_w_valid = 0; bus.dmem_w_strb = '0; bus.dmem_w_data = '0;

    // Reset state
    settle();
    chk("rst_ready", rdy(), 32'h0);
    chk("rst_rvalid", rvld(), 32'h0);
    chk("rst_wready", {31'd0, bus.dmem_w_ready}, 32'h0);
    chk("rst_pulses", {30'd0, mem_wren, mem_rden}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    tick(); tick();
    rst = 1'b1;

    // 1: imem read of 0x100, data two cycles after accept
    bus.imem_addr = 32'h100; bus.imem_valid = 1;
    settle();
    chk("t1_ready", rdy(), 32'h1);
    chk("t1_rden", {31'd0, mem_rden}, 32'h1);
    chk("t1_mem_addr", mem_addr, 32'h40);
    tick();
    bus.imem_valid = 0;
    settle();
    chk("t1_rvalid_t1", rvld(), 32'h0);
    chk("t1_rden_t1", {31'd0, mem_rden}, 32'h0);
    tick();
    chk("t1_rvalid_t2", rvld(), 32'h1);
    chk("t1_rdata", bus.imem_r_data, 32'hDEADBEEF);
    bus.imem_r_ready = 1;
    tick();
    bus.imem_r_ready = 0;
    settle();
    chk("t1_idle_rvalid", rvld(), 32'h0);

    // 2: reset, then both requesting reads continuously: grants alternate
    rst = 1'b0; tick(); rst = 1'b1;
    bus.imem_addr = 32'h100; bus.dmem_addr = 32'h200; bus.dmem_cmd = CMD_RD;
    bus.imem_valid = 1; bus.dmem_valid = 1;
    bus.imem_r_ready = 1; bus.dmem_r_ready = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("t2_grant%0d", i), rdy(), (i % 2 == 1) ? 32'h2 : 32'h1);
      tick();
      chk($sformatf("t2_rdmem_ready%0d", i), rdy(), 32'h0);
      tick();
      chk($sformatf("t2_rsp_ready%0d", i), rdy(), 32'h0);
      chk($sformatf("t2_rvalid%0d", i), rvld(), (i % 2 == 1) ? 32'h2 : 32'h1);
      chk($sformatf("t2_rdata%0d", i), (i % 2 == 1) ? bus.dmem_r_data : bus.imem_r_data,
          (i % 2 == 1) ? 32'hCAFEF00D : 32'hDEADBEEF);
      tick();
    end
    bus.imem_valid = 0; bus.dmem_valid = 0;
    bus.imem_r_ready = 0; bus.dmem_r_ready = 0;

    // 3: dmem write 0x200, strobes 0101, write data three cycles late
    bus.dmem_addr = 32'h200; bus.dmem_cmd = CMD_WR; bus.dmem_valid = 1;
    settle();
    chk("t3_ready", rdy(), 32'h2);
    chk("t3_accept_pulses", {30'd0, mem_wren, mem_rden}, 32'h0);
    tick();
    bus.dmem_valid = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("t3_wready%0d", i), {31'd0, bus.dmem_w_ready}, 32'h1);
      chk($sformatf("t3_nowren%0d", i), {31'd0, mem_wren}, 32'h0);
      tick();
    end
    bus.dmem_w_valid = 1; bus.dmem_w_strb = 4'b0101; bus.dmem_w_data = 32'h11223344;
    settle();
    chk("t3_wren", {31'd0, mem_wren}, 32'h1);
    chk("t3_waddr", mem_addr, 32'h80);
    chk("t3_wstrb", {28'd0, mem_wrstrb}, 32'h5);
    chk("t3_wdata", mem_wrdata, 32'h11223344);
    tick();
    bus.dmem_w_valid = 0;
    settle();
    chk("t3_after_wren", {31'd0, mem_wren}, 32'h0);
    chk("t3_after_wready", {31'd0, bus.dmem_w_ready}, 32'h0);
    bus.dmem_cmd = CMD_RD; bus.dmem_valid = 1;
    settle();
    chk("t3_rd_ready", rdy(), 32'h2);
    tick();
    bus.dmem_valid = 0;
    tick();
    chk("t3_rd_rvalid", rvld(), 32'h2);
    chk("t3_rd_data", bus.dmem_r_data, 32'hCA22F044);
    bus.dmem_r_ready = 1;
    tick();
    bus.dmem_r_ready = 0;

    // 4: imem response back-pressured; dmem read waits until IDLE
    bus.imem_addr = 32'h100; bus.imem_valid = 1;
    settle();
    chk("t4_ready", rdy(), 32'h1);
    tick();
    bus.imem_valid = 0;
    tick();
    bus.dmem_addr = 32'h200; bus.dmem_cmd = CMD_RD; bus.dmem_valid = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("t4_rvalid%0d", i), rvld(), 32'h1);
      chk($sformatf("t4_rdata%0d", i), bus.imem_r_data, 32'hDEADBEEF);
      chk($sformatf("t4_norden%0d", i), {31'd0, mem_rden}, 32'h0);
      chk($sformatf("t4_dready%0d", i), rdy(), 32'h0);
      tick();
    end
    bus.imem_r_ready = 1;
    settle();
    chk("t4_release_ready", rdy(), 32'h0);
    tick();
    bus.imem_r_ready = 0;
    settle();
    chk("t4_idle_ready", rdy(), 32'h2);
    chk("t4_idle_rden", {31'd0, mem_rden}, 32'h1);
    chk("t4_idle_addr", mem_addr, 32'h80);
    tick();
    bus.dmem_valid = 0;
    tick();
    chk("t4_d_rdata", bus.dmem_r_data, 32'hCA22F044);
    bus.dmem_r_ready = 1;
    tick();
    bus.dmem_r_ready = 0;

    // 5: reset asserted while waiting for write data aborts the write
    bus.dmem_addr = 32'h300; bus.dmem_cmd = CMD_WR; bus.dmem_valid = 1;
    tick();
    bus.dmem_valid = 0;
    settle();
    chk("t5_wready", {31'd0, bus.dmem_w_ready}, 32'h1);
    bus.dmem_w_valid = 1; bus.dmem_w_strb = 4'hF; bus.dmem_w_data = 32'hFFFFFFFF;
    rst = 1'b0;
    settle();
    chk("t5_rst_wready", {31'd0, bus.dmem_w_ready}, 32'h0);
    chk("t5_rst_wren", {31'd0, mem_wren}, 32'h0);
    chk("t5_rst_addr", mem_addr, 32'h0);
    chk("t5_rst_wdata", mem_wrdata, 32'h0);
    tick();
    bus.dmem_cmd = CMD_RD; bus.imem_valid = 1; bus.dmem_valid = 1;
    settle();
    chk("t5_rst_ready", rdy(), 32'h0);
    chk("t5_rst_wren2", {31'd0, mem_wren}, 32'h0);
    tick();
    bus.dmem_w_valid = 0;
    rst = 1'b1;
    settle();
    chk("t5_first_grant", rdy(), 32'h1);
    tick();
    bus.imem_valid = 0; bus.dmem_valid = 0;
    tick();
    chk("t5_rvalid", rvld(), 32'h1);
    bus.imem_r_ready = 1;
    tick();
    bus.imem_r_ready = 0;
    chk("t5_no_write", ram[8'hC0], 32'h0);

    // 6: unaligned dmem read of 0x3 maps to word 0
    bus.dmem_addr = 32'h3; bus.dmem_cmd = CMD_RD; bus.dmem_valid = 1;
    settle();
    chk("t6_ready", rdy(), 32'h2);
    chk("t6_addr", mem_addr, 32'h0);
    chk("t6_rden", {31'd0, mem_rden}, 32'h1);
    tick();
    bus.dmem_valid = 0;
    settle();
    chk("t6_rvalid_t1", rvld(), 32'h0);
    tick();
    chk("t6_rvalid_t2", rvld(), 32'h2);
    chk("t6_rdata", bus.dmem_r_data, 32'h0BADF00D);
    bus.dmem_r_ready = 1;
    tick();
    bus.dmem_r_ready = 0;
    settle();
    chk("t6_idle", rvld(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
